// File: rtl/reversi_eval_pkg.sv
// Shared widths, FSM encoding and score limits for the evaluation accumulator.
package reversi_eval_pkg;
  localparam int PROD_W = 28;
  localparam int ACC_W  = 36;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam logic [OUT_W-1:0] SCORE_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SCORE_MIN = {1'b1, {(OUT_W-1){1'b0}}};
endpackage

// File: rtl/reversi_eval_sat.sv
// Signed narrowing IN_W -> O_W with clipping to the most positive/negative value.
module reversi_eval_sat
  import reversi_eval_pkg::*;
#(
  parameter int IN_W = ACC_W,
  parameter int O_W  = OUT_W
) (
  input  logic signed [IN_W-1:0] sum_i,
  output logic signed [O_W-1:0]  score_o,
  output logic                   clip_o
);
  localparam logic [O_W-1:0] MAXV = {1'b0, {(O_W-1){1'b1}}};
  localparam logic [O_W-1:0] MINV = {1'b1, {(O_W-1){1'b0}}};

  // The value fits when every bit from the output sign bit upward agrees.
  logic [IN_W-O_W:0] hi;
  logic              fits;
  assign hi   = sum_i[IN_W-1:O_W-1];
  assign fits = (&hi) | ~(|hi);

  // Pass through when representable, otherwise clip toward the input sign.
  always_comb begin
    score_o = sum_i[O_W-1:0];
    clip_o  = 1'b0;
    if (!fits) begin
      clip_o  = 1'b1;
      score_o = sum_i[IN_W-1] ? MINV : MAXV;
    end
  end
endmodule

// File: rtl/reversi_eval_accum.sv
// Sums signed product beats of one position and presents a saturated score
// on a valid/ready output; in_ready depends only on state.
module reversi_eval_accum #(
  parameter int PROD_W = reversi_eval_pkg::PROD_W,
  parameter int ACC_W  = reversi_eval_pkg::ACC_W,
  parameter int OUT_W  = reversi_eval_pkg::OUT_W,
  parameter int CNT_W  = reversi_eval_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     ap_rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_score,
  output logic [CNT_W-1:0]         out_terms,
  output logic                     out_sat,
  output logic                     out_ovf
);
  typedef reversi_eval_pkg::state_e state_e;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, prod_ext;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic signed [OUT_W-1:0]  score_q, sat_score;
  logic [CNT_W-1:0]         terms_q;
  logic                     sat_q, oovf_q, clip;
  logic                     accept, load_out;

  assign in_ready  = (state_q != reversi_eval_pkg::HOLD);
  assign out_valid = (state_q == reversi_eval_pkg::HOLD);
  assign accept    = in_valid && in_ready;
  assign prod_ext  = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign load_out  = !clear && accept && in_last;

  assign out_score = score_q;
  assign out_terms = terms_q;
  assign out_sat   = sat_q;
  assign out_ovf   = oovf_q;

  // Saturate the sum that includes the current beat, so the result register
  // can load on the same edge the last beat is accepted.
  reversi_eval_sat #(.IN_W(ACC_W), .O_W(OUT_W)) u_sat (
    .sum_i   (acc_d),
    .score_o (sat_score),
    .clip_o  (clip)
  );

  // Next-state and datapath update; clear overrides any beat this cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = reversi_eval_pkg::IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        reversi_eval_pkg::IDLE: if (accept) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? reversi_eval_pkg::HOLD : reversi_eval_pkg::ACCUM;
        end
        reversi_eval_pkg::ACCUM: if (accept) begin
          acc_d = acc_q + prod_ext;
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = reversi_eval_pkg::HOLD;
        end
        reversi_eval_pkg::HOLD: if (out_ready) state_d = reversi_eval_pkg::IDLE;
        default: state_d = reversi_eval_pkg::IDLE;
      endcase
    end
  end

  // State and running sum registers.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= reversi_eval_pkg::IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers load only when the last beat is taken, so they stay
  // stable for as long as the consumer stalls.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      score_q <= '0;
      terms_q <= '0;
      sat_q   <= 1'b0;
      oovf_q  <= 1'b0;
    end else if (load_out) begin
      score_q <= sat_score;
      terms_q <= cnt_d;
      sat_q   <= clip;
      oovf_q  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_reversi_eval_accum.sv
// Directed bench for reversi_eval_accum: table of uniform positions plus
// hand sequences for stall, clear and asynchronous reset.
module tb_reversi_eval_accum;
  logic        clk = 1'b0;
  logic        ap_rst_n, clear, in_valid, in_last, out_ready;
  logic [27:0] in_prod;
  logic        in_ready, out_valid, out_sat, out_ovf;
  logic [31:0] out_score;
  logic [7:0]  out_terms;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reversi_eval_accum dut (
    .clk       (clk),
    .ap_rst_n  (ap_rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_score (out_score),
    .out_terms (out_terms),
    .out_sat   (out_sat),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    string       name;
    int          n;
    logic [27:0] v0;
    logic [27:0] vr;
    logic [31:0] score;
    int          terms;
    bit          sat;
    bit          ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one beat, returns at the negedge after its edge.
  task automatic beat(input logic [27:0] v, input bit last);
    int t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_prod = v; in_last = last;
    if (last) chk("pre_last_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_pos(input int n, input logic [27:0] v0, input logic [27:0] vr, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) @(negedge clk);
      beat(i == 0 ? v0 : vr, i == n - 1);
    end
  endtask

  // Checks the pending result one cycle after the last accept, then consumes it.
  task automatic collect(input string nm, input logic [31:0] sc, input int terms,
                         input bit sat, input bit ovf);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".in_ready"},  64'(in_ready),  64'd0);
    chk({nm, ".score"},     64'(out_score), 64'(sc));
    chk({nm, ".terms"},     64'(out_terms), 64'(terms));
    chk({nm, ".sat"},       64'(out_sat),   64'(sat));
    chk({nm, ".ovf"},       64'(out_ovf),   64'(ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, ".drop_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".ready_back"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{"max255", 255, 28'h7FFFFFF, 28'h7FFFFFF, 32'h7FFFFFFF, 255, 1'b1, 1'b0};
    vecs[1] = '{"min255", 255, 28'h8000000, 28'h8000000, 32'h80000000, 255, 1'b1, 1'b0};
    vecs[2] = '{"ovf256", 256, 28'h0000001, 28'h0000001, 32'h00000100, 255, 1'b0, 1'b1};
    vecs[3] = '{"single", 1,   28'hFFFFFF7, 28'h0000000, 32'hFFFFFFF7, 1,   1'b0, 1'b0};
    vecs[4] = '{"max16",  16,  28'h7FFFFFF, 28'h7FFFFFF, 32'h7FFFFFF0, 16,  1'b0, 1'b0};
    vecs[5] = '{"max17",  17,  28'h7FFFFFF, 28'h7FFFFFF, 32'h7FFFFFFF, 17,  1'b1, 1'b0};
    vecs[6] = '{"min16",  16,  28'h8000000, 28'h8000000, 32'h80000000, 16,  1'b0, 1'b0};
    vecs[7] = '{"min17",  17,  28'h8000000, 28'h8000000, 32'h80000000, 17,  1'b1, 1'b0};
    vecs[8] = '{"mix",    3,   28'h0000005, 28'hFFFFFFE, 32'h00000001, 3,   1'b0, 1'b0};
    vecs[9] = '{"cancel", 2,   28'h7FFFFFF, 28'h8000000, 32'hFFFFFFFF, 2,   1'b0, 1'b0};

    ap_rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_prod = '0;
    #3;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.score",     64'(out_score), 64'd0);
    chk("rst.terms",     64'(out_terms), 64'd0);
    chk("rst.flags",     64'({out_sat, out_ovf}), 64'd0);
    @(negedge clk); @(negedge clk);
    ap_rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    // First position, then a 10-cycle consumer stall before it is taken.
    beat(28'd1000, 1'b0);
    beat(28'hFFFFF06, 1'b0);
    beat(28'd7, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("stall.valid", 64'(out_valid), 64'd1);
      chk("stall.ready", 64'(in_ready),  64'd0);
      chk("stall.score", 64'(out_score), 64'd757);
      @(negedge clk);
    end
    collect("p757", 32'd757, 3, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      run_pos(vecs[k].n, vecs[k].v0, vecs[k].vr, k % 2 == 0);
      collect(vecs[k].name, vecs[k].score, vecs[k].terms, vecs[k].sat, vecs[k].ovf);
    end

    // Clear mid-position, with a beat offered in the same cycle.
    beat(28'd5, 1'b0);
    beat(28'd6, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_prod = 28'd100; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr.out_valid", 64'(out_valid), 64'd0);
    chk("clr.in_ready",  64'(in_ready),  64'd1);
    beat(28'hFFFFFF7, 1'b1);
    collect("clr_single", 32'hFFFFFFF7, 1, 1'b0, 1'b0);

    // Clear while a score is pending drops it.
    beat(28'd50, 1'b1);
    chk("clrhold.valid", 64'(out_valid), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrhold.drop",  64'(out_valid), 64'd0);
    chk("clrhold.ready", 64'(in_ready),  64'd1);
    beat(28'd3, 1'b1);
    collect("after_clr", 32'd3, 1, 1'b0, 1'b0);

    // Asynchronous reset with a pending score, away from any clock edge.
    beat(28'd10, 1'b0);
    beat(28'd20, 1'b0);
    beat(28'd30, 1'b1);
    chk("arst.pre_valid", 64'(out_valid), 64'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.score", 64'(out_score), 64'd0);
    chk("arst.terms", 64'(out_terms), 64'd0);
    chk("arst.flags", 64'({out_sat, out_ovf}), 64'd0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    @(negedge clk);
    beat(28'd4, 1'b0);
    beat(28'd2, 1'b1);
    collect("post_rst", 32'd6, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
